yutorina_rom_arbiter: RTL

Two-master arbiter and access sequencer for the on-chip ROM slave. It sits between the instruction-fetch port (master 0) and the data/boot-loader port (master 1) on one side and the single ROM slave on the other. It accepts one request at a time and drives the ROM's active-low chip-select/address-strobe pair. It captures the ROM read word on the ROM's ready, returns it to the granted master with a one-cycle ready pulse, and flags an error if the ROM never answers.

---
 rtl/yutorina_rom_arbiter_if.sv | 39 +++
 rtl/yutorina_rom_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/yutorina_rom_arbiter_if.sv
// Bus bundle between the two ROM masters, the arbiter and the ROM slave.
// The arbiter connects through the slave modport; the environment uses master.
interface yutorina_rom_arbiter_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);
  // master 0 (instruction fetch)
  logic              m0_as_;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_rd_data;
  logic              m0_rdy_;
  logic              m0_err;
  // master 1 (data / boot loader)
  logic              m1_as_;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_rd_data;
  logic              m1_rdy_;
  logic              m1_err;
  // ROM slave
  logic              rom_cs_;
  logic              rom_as_;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rd_data;
  logic              rom_rdy_;
  // status
  logic              busy;

  modport slave (
    input  m0_as_, m0_addr, m1_as_, m1_addr, rom_rd_data, rom_rdy_,
    output m0_rd_data, m0_rdy_, m0_err, m1_rd_data, m1_rdy_, m1_err,
           rom_cs_, rom_as_, rom_addr, busy
  );

  modport master (
    output m0_as_, m0_addr, m1_as_, m1_addr, rom_rd_data, rom_rdy_,
    input  m0_rd_data, m0_rdy_, m0_err, m1_rd_data, m1_rdy_, m1_err,
           rom_cs_, rom_as_, rom_addr, busy
  );
endinterface

// File: rtl/yutorina_rom_arbiter.sv
// Two-master arbiter and access sequencer for the on-chip ROM.
// Config macro: ROM_ARB_FIXED_PRIO_EN -- when defined master 0 always wins a
// contended arbitration; otherwise arbitration is round-robin.
module yutorina_rom_arbiter #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   rst,
  yutorina_rom_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] m0_data_q, m0_data_d, m1_data_q, m1_data_d;
  logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic              rom_sel_q, rom_sel_d;
  logic              m0_rdy_q, m0_rdy_d, m1_rdy_q, m1_rdy_d;
  logic              busy_q, busy_d;
`ifndef ROM_ARB_FIXED_PRIO_EN
  logic              last_grant_q, last_grant_d;
`endif
  logic              pick_m1;
  logic              resp_load;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      m0_data_q    <= '0;
      m1_data_q    <= '0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      rom_sel_q    <= 1'b1;
      m0_rdy_q     <= 1'b1;
      m1_rdy_q     <= 1'b1;
      busy_q       <= 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      m0_data_q    <= m0_data_d;
      m1_data_q    <= m1_data_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
      rom_sel_q    <= rom_sel_d;
      m0_rdy_q     <= m0_rdy_d;
      m1_rdy_q     <= m1_rdy_d;
      busy_q       <= busy_d;
`ifndef ROM_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Next state, arbitration, response capture; outputs follow the next state
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    m0_data_d = m0_data_q;
    m1_data_d = m1_data_q;
    m0_err_d  = m0_err_q;
    m1_err_d  = m1_err_q;
    pick_m1   = 1'b0;
    resp_load = 1'b0;
    resp_data = '0;
    resp_err  = 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (!bus.m0_as_ || !bus.m1_as_) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
          pick_m1 = bus.m0_as_;
`else
          pick_m1      = !bus.m1_as_ && (bus.m0_as_ || !last_grant_q);
          last_grant_d = pick_m1;
`endif
          grant_d = pick_m1;
          addr_d  = pick_m1 ? bus.m1_addr : bus.m0_addr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!bus.rom_rdy_) begin
          resp_load = 1'b1;
          resp_data = bus.rom_rd_data;
          state_d   = DONE;
        end else if (cnt_q == CNT_LAST) begin
          // TIMEOUT WAIT cycles elapsed without an answer
          resp_load = 1'b1;
          resp_err  = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    if (resp_load) begin
      if (grant_q) begin
        m1_data_d = resp_data;
        m1_err_d  = resp_err;
      end else begin
        m0_data_d = resp_data;
        m0_err_d  = resp_err;
      end
    end

    rom_sel_d = (state_d != ISSUE);
    m0_rdy_d  = !((state_d == DONE) && !grant_d);
    m1_rdy_d  = !((state_d == DONE) && grant_d);
    busy_d    = (state_d != IDLE);
  end

  assign bus.rom_cs_    = rom_sel_q;
  assign bus.rom_as_    = rom_sel_q;
  assign bus.rom_addr   = addr_q;
  assign bus.m0_rd_data = m0_data_q;
  assign bus.m0_err     = m0_err_q;
  assign bus.m0_rdy_    = m0_rdy_q;
  assign bus.m1_rd_data = m1_data_q;
  assign bus.m1_err     = m1_err_q;
  assign bus.m1_rdy_    = m1_rdy_q;
  assign bus.busy       = busy_q;

endmodule
